// File: rtl/n4_b2_incr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : n4_b2_incr_arbiter
// Purpose  : Round-robin arbiter sharing one 4-bit incrementer (x + cin)
//            among N_REQ requesters; returns s/cout with a one-cycle ack.
// Options  : INCR_ARB_SAT_EN - saturate s to 4'hF on carry-out.
// Revision : 1.0 - initial release
// ============================================================================
module n4_b2_incr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int GID_W = $clog2(N_REQ)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [4*N_REQ-1:0] x_flat_i,
  input  logic [N_REQ-1:0]   cin_flat_i,
  output logic [N_REQ-1:0]   ack_o,
  output logic [3:0]         s_o,
  output logic               cout_o,
  output logic [GID_W-1:0]   grant_id_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [GID_W-1:0] gid_q, gid_d;
  logic [GID_W-1:0] last_q, last_d;
  logic [3:0]       op_x_q, op_x_d;
  logic             op_cin_q, op_cin_d;
  logic [3:0]       s_q, s_d;
  logic             cout_q, cout_d;

  logic             pick_vld_w;
  logic [GID_W-1:0] pick_id_w;
  logic [GID_W-1:0] cand_w;
  logic [4:0]       sum_w;
  logic [3:0]       res_s_w;
  logic             res_c_w;

  // Scan offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left standing.
  always_comb begin
    pick_vld_w = 1'b0;
    pick_id_w  = '0;
    cand_w     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_w = GID_W'((int'(last_q) + k) % N_REQ);
      if (req_i[cand_w]) begin
        pick_vld_w = 1'b1;
        pick_id_w  = cand_w;
      end
    end
  end

  assign sum_w = {1'b0, op_x_q} + {4'b0000, op_cin_q};

`ifdef INCR_ARB_SAT_EN
  assign res_s_w = sum_w[4] ? 4'hF : sum_w[3:0];
  assign res_c_w = sum_w[4];
`else
  assign res_s_w = sum_w[3:0];
  assign res_c_w = sum_w[4];
`endif

  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    last_d   = last_q;
    op_x_d   = op_x_q;
    op_cin_d = op_cin_q;
    s_d      = s_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (pick_vld_w) begin
          gid_d    = pick_id_w;
          op_x_d   = x_flat_i[{pick_id_w, 2'b00} +: 4];
          op_cin_d = cin_flat_i[pick_id_w];
          state_d  = EXEC;
        end
      end
      EXEC: begin
        s_d     = res_s_w;
        cout_d  = res_c_w;
        state_d = DONE;
      end
      DONE: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      last_q   <= GID_W'(N_REQ - 1);
      op_x_q   <= 4'h0;
      op_cin_q <= 1'b0;
      s_q      <= 4'h0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      op_x_q   <= op_x_d;
      op_cin_q <= op_cin_d;
      s_q      <= s_d;
      cout_q   <= cout_d;
    end
  end

  assign ack_o      = (state_q == DONE) ? (N_REQ'(1) << gid_q) : '0;
  assign busy_o     = (state_q != IDLE);
  assign s_o        = s_q;
  assign cout_o     = cout_q;
  assign grant_id_o = gid_q;

endmodule
`default_nettype wire

// File: tb/tb_n4_b2_incr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_n4_b2_incr_arbiter
// Purpose  : Scoreboard bench for n4_b2_incr_arbiter (expected acks queued).
// Revision : 1.0 - initial release
// ============================================================================
module tb_n4_b2_incr_arbiter;

  localparam int N = 4;
  localparam int GW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [4*N-1:0] x_flat;
  logic [N-1:0]   cin_flat;
  logic [N-1:0]   ack;
  logic [3:0]     s;
  logic           cout;
  logic [GW-1:0]  gid;
  logic           busy;

  n4_b2_incr_arbiter #(.N_REQ(N)) dut (
    .clock_i    (clk),
    .reset_i    (rst),
    .req_i      (req),
    .x_flat_i   (x_flat),
    .cin_flat_i (cin_flat),
    .ack_o      (ack),
    .s_o        (s),
    .cout_o     (cout),
    .grant_id_o (gid),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] s;
    logic       c;
  } exp_t;

  exp_t   q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  int     last_ack = -1;
  logic   tput_en = 1'b0;
  logic [N-1:0] hold = '0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model_inc(input logic [3:0] x, input logic c);
    logic [4:0] r;
    r = {1'b0, x} + {4'b0000, c};
`ifdef INCR_ARB_SAT_EN
    if (r[4]) r = 5'h1F;
`endif
    return r;
  endfunction

  task automatic set_op(input int i, input logic [3:0] x, input logic c);
    x_flat[4*i +: 4] = x;
    cin_flat[i]      = c;
  endtask

  task automatic push_exp(input int id, input logic [3:0] x, input logic c);
    exp_t       e;
    logic [4:0] r;
    r    = model_inc(x, c);
    e.id = id;
    e.s  = r[3:0];
    e.c  = r[4];
    q.push_back(e);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    check_eq("drain", q.size(), 0);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle", busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack !== '0) begin
        if (q.size() == 0) begin
          check_eq("unexp_ack", ack, 0);
        end else begin
          e = q.pop_front();
          check_eq("ack", ack, 32'(1) << e.id);
          check_eq("s", s, e.s);
          check_eq("cout", cout, e.c);
          check_eq("gid", gid, e.id);
          if (tput_en && last_ack >= 0) check_eq("tput", cyc - last_ack, 3);
          last_ack = cyc;
        end
        for (int i = 0; i < N; i++)
          if (ack[i] && !hold[i]) req[i] = 1'b0;
      end
    end
  end

  initial begin
    x_flat   = '0;
    cin_flat = '0;
    do_reset();
    check_eq("rst_ack", ack, 0);
    check_eq("rst_s", s, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_gid", gid, 0);

    // Single request, latency: ack exactly two cycles after request edge
    set_op(0, 4'h5, 1'b1);
    push_exp(0, 4'h5, 1'b1);
    req[0] = 1'b1;
    @(negedge clk);
    check_eq("lat1_ack", ack, 0);
    check_eq("lat1_busy", busy, 1);
    @(negedge clk); #1;
    check_eq("lat2_ack", ack, 4'b0001);
    wait_drain(5);

    // Overflow case, then pass-through
    wait_idle(5);
    set_op(1, 4'hF, 1'b1);
    push_exp(1, 4'hF, 1'b1);
    req[1] = 1'b1;
    wait_drain(10);
    wait_idle(5);
    set_op(1, 4'h3, 1'b0);
    push_exp(1, 4'h3, 1'b0);
    req[1] = 1'b1;
    wait_drain(10);

    // Fresh round-robin from reset: all four, one ack every 3 cycles
    wait_idle(5);
    do_reset();
    set_op(0, 4'h8, 1'b1);
    set_op(1, 4'hF, 1'b1);
    set_op(2, 4'h2, 1'b0);
    set_op(3, 4'hE, 1'b1);
    for (int i = 0; i < N; i++) push_exp(i, x_flat[4*i +: 4], cin_flat[i]);
    tput_en  = 1'b1;
    last_ack = -1;
    req      = 4'b1111;
    wait_drain(30);
    tput_en  = 1'b0;

    // Two held requesters alternate (last grant was 3 -> 0 first)
    wait_idle(5);
    hold = 4'b0101;
    push_exp(0, 4'h8, 1'b1);
    push_exp(2, 4'h2, 1'b0);
    push_exp(0, 4'h8, 1'b1);
    push_exp(2, 4'h2, 1'b0);
    req = 4'b0101;
    wait_drain(30);
    req  = '0;
    hold = '0;

    // Operand change after grant must not affect the result
    wait_idle(5);
    set_op(0, 4'h5, 1'b1);
    push_exp(0, 4'h5, 1'b1);
    req[0] = 1'b1;
    @(posedge clk); #1;
    set_op(0, 4'hA, 1'b1);
    wait_drain(10);

    // Reset during EXEC aborts the operation
    wait_idle(5);
    set_op(2, 4'h7, 1'b1);
    req = 4'b0100;
    @(posedge clk); #1;
    check_eq("exec_busy", busy, 1);
    check_eq("exec_gid", gid, 2);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_ack", ack, 0);
    check_eq("abort_s", s, 0);
    check_eq("abort_cout", cout, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_gid", gid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // After reset, requester 1 wins before 3
    set_op(1, 4'h2, 1'b1);
    set_op(3, 4'h9, 1'b0);
    push_exp(1, 4'h2, 1'b1);
    push_exp(3, 4'h9, 1'b0);
    req = 4'b1010;
    wait_drain(20);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
